// File: rtl/cpu_pkg.sv
// Definitions shared between the branch unit and the instruction decoder:
// branch FSM states plus the C-field offset width and the reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } branchState_t;

    localparam int          OFFSET_WIDTH = 19;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;

endpackage

// File: rtl/pc_branch_unit_sat_counter.sv
// Saturating up-counter used for the branch statistics; holds at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] countReg;
    logic [CNT_WIDTH-1:0] countNext;

    always_comb begin
        countNext = countReg;
        if (inc && (countReg != '1)) begin
            countNext = countReg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

    assign count = countReg;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with a three-state conditional-branch resolver sitting behind
// the CON flip-flop, bus loads for jr/jal, and saturating branch statistics.
module pc_branch_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  OFFSET_WIDTH = cpu_pkg::OFFSET_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(cpu_pkg::RESET_PC),
    parameter int                  CNT_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    con_in,
    input  logic                    pc_inc,
    input  logic                    pc_load,
    input  logic                    branch_req,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [PC_WIDTH-1:0]     bus_in,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic                    busy,
    output logic                    branch_taken,
    output logic                    overlap_err,
    output logic [CNT_WIDTH-1:0]    branch_cnt,
    output logic [CNT_WIDTH-1:0]    taken_cnt
);
    import cpu_pkg::*;

    branchState_t            stateReg;
    branchState_t            stateNext;
    logic [PC_WIDTH-1:0]     pcReg;
    logic [PC_WIDTH-1:0]     pcNext;
    logic [OFFSET_WIDTH-1:0] offsetReg;
    logic [OFFSET_WIDTH-1:0] offsetNext;
    logic                    conQReg;
    logic                    conQNext;
    logic                    takenReg;
    logic                    takenNext;
    logic                    overlapReg;
    logic                    overlapNext;

    logic [PC_WIDTH-1:0]     offsetExt;
    logic [PC_WIDTH-1:0]     branchTarget;
    logic                    busyNow;
    logic [1:0]              statInc;
    logic [CNT_WIDTH-1:0]    statCount [2];

    // PC already points past the branch, so the target is simply PC + C (mod 2^PC_WIDTH).
    assign offsetExt    = {{(PC_WIDTH-OFFSET_WIDTH){offsetReg[OFFSET_WIDTH-1]}}, offsetReg};
    assign branchTarget = pcReg + offsetExt;
    assign busyNow      = (stateReg != IDLE);

    always_comb begin
        stateNext   = IDLE;
        pcNext      = pcReg;
        offsetNext  = offsetReg;
        conQNext    = conQReg;
        takenNext   = 1'b0;
        overlapNext = overlapReg;
        statInc     = 2'b00;

        // A bus load during a branch is a legitimate abort, not a collision.
        if (busyNow && !pc_load && (pc_inc || branch_req)) begin
            overlapNext = 1'b1;
        end

        case (stateReg)
            IDLE: begin
                if (branch_req) begin
                    stateNext  = EVAL;
                    offsetNext = offset;
                end
                if (pc_load) begin
                    pcNext = bus_in;
                end else if (pc_inc) begin
                    pcNext = pcReg + PC_WIDTH'(1);
                end
            end
            EVAL: begin
                // CON settles one cycle after the request, so it is captured here.
                conQNext = con_in;
                if (pc_load) begin
                    pcNext    = bus_in;
                    stateNext = IDLE;
                end else begin
                    stateNext = COMMIT;
                end
            end
            COMMIT: begin
                stateNext = IDLE;
                if (pc_load) begin
                    pcNext = bus_in;
                end else begin
                    statInc[0] = 1'b1;
                    if (conQReg) begin
                        pcNext     = branchTarget;
                        takenNext  = 1'b1;
                        statInc[1] = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stateReg   <= IDLE;
            pcReg      <= RESET_PC;
            offsetReg  <= '0;
            conQReg    <= 1'b0;
            takenReg   <= 1'b0;
            overlapReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            offsetReg  <= offsetNext;
            conQReg    <= conQNext;
            takenReg   <= takenNext;
            overlapReg <= overlapNext;
        end
    end

    // Index 0 counts resolved branches, index 1 counts taken ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gStat
            sat_counter #(
                .CNT_WIDTH(CNT_WIDTH)
            ) uStat (
                .clock  (clock),
                .clear_n(clear_n),
                .inc    (statInc[gi]),
                .count  (statCount[gi])
            );
        end
    endgenerate

    assign pc_out       = pcReg;
    assign busy         = busyNow;
    assign branch_taken = takenReg;
    assign overlap_err  = overlapReg;
    assign branch_cnt   = statCount[0];
    assign taken_cnt    = statCount[1];

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit (CNT_WIDTH=4 build) with an expected-result queue.
module tb_pc_branch_unit;

    localparam int PCW = 32;
    localparam int OFW = 19;
    localparam int CW  = 4;

    logic           clock      = 1'b0;
    logic           clear_n    = 1'b1;
    logic           con_in     = 1'b0;
    logic           pc_inc     = 1'b0;
    logic           pc_load    = 1'b0;
    logic           branch_req = 1'b0;
    logic [OFW-1:0] offset     = '0;
    logic [PCW-1:0] bus_in     = '0;
    logic [PCW-1:0] pc_out;
    logic           busy;
    logic           branch_taken;
    logic           overlap_err;
    logic [CW-1:0]  branch_cnt;
    logic [CW-1:0]  taken_cnt;

    pc_branch_unit #(
        .PC_WIDTH    (PCW),
        .OFFSET_WIDTH(OFW),
        .RESET_PC    (32'h0),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .con_in      (con_in),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .branch_req  (branch_req),
        .offset      (offset),
        .bus_in      (bus_in),
        .pc_out      (pc_out),
        .busy        (busy),
        .branch_taken(branch_taken),
        .overlap_err (overlap_err),
        .branch_cnt  (branch_cnt),
        .taken_cnt   (taken_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        taken;
        logic [3:0]  bcnt;
        logic [3:0]  tcnt;
    } exp_t;

    exp_t        sbQ[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mPc   = 32'h0;
    logic [3:0]  mB    = 4'h0;
    logic [3:0]  mT    = 4'h0;
    logic        mOvl  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, ".pc"},      pc_out, mPc);
        chk({tag, ".busy"},    32'(busy), 32'h0);
        chk({tag, ".taken"},   32'(branch_taken), 32'h0);
        chk({tag, ".overlap"}, 32'(overlap_err), 32'(mOvl));
        chk({tag, ".bcnt"},    32'(branch_cnt), 32'(mB));
        chk({tag, ".tcnt"},    32'(taken_cnt), 32'(mT));
    endtask

    task automatic loadPc(input string tag, input logic [31:0] v);
        pc_load = 1'b1;
        bus_in  = v;
        tick();
        pc_load = 1'b0;
        bus_in  = 32'hDEAD_BEEF;
        mPc     = v;
        chkIdle({tag, ".load"});
    endtask

    // Full branch: request at edge N, CON at edge N+1, PC/pulse at edge N+2.
    task automatic doBranch(input string tag, input logic [OFW-1:0] off, input logic con);
        exp_t e;
        exp_t got;
        int   so;
        branch_req = 1'b1;
        offset     = off;
        tick();
        branch_req = 1'b0;
        offset     = ~off;
        chk({tag, ".n1.busy"},  32'(busy), 32'h1);
        chk({tag, ".n1.pc"},    pc_out, mPc);
        chk({tag, ".n1.taken"}, 32'(branch_taken), 32'h0);
        con_in = con;
        so = int'(off);
        if (off[OFW-1]) so = so - (1 << OFW);
        if (mB != 4'hF) mB = mB + 4'h1;
        if (con) begin
            if (mT != 4'hF) mT = mT + 4'h1;
            mPc = mPc + 32'(so);
        end
        e.tag = tag; e.pc = mPc; e.taken = con; e.bcnt = mB; e.tcnt = mT;
        sbQ.push_back(e);
        tick();
        con_in = ~con;
        chk({tag, ".n2.busy"},  32'(busy), 32'h1);
        chk({tag, ".n2.taken"}, 32'(branch_taken), 32'h0);
        tick();
        con_in = 1'b0;
        got = sbQ.pop_front();
        chk({got.tag, ".pc"},    pc_out, got.pc);
        chk({got.tag, ".taken"}, 32'(branch_taken), 32'(got.taken));
        chk({got.tag, ".bcnt"},  32'(branch_cnt), 32'(got.bcnt));
        chk({got.tag, ".tcnt"},  32'(taken_cnt), 32'(got.tcnt));
        chk({got.tag, ".busy"},  32'(busy), 32'h0);
        $display("txn %s off=0x%05h con=%0d pc=0x%08h bcnt=%0d tcnt=%0d",
                 tag, off, con, pc_out, branch_cnt, taken_cnt);
        tick();
        chk({tag, ".pulse1cyc"}, 32'(branch_taken), 32'h0);
        chk({tag, ".hold"},      pc_out, mPc);
    endtask

    initial begin
        // Reset state
        #2 clear_n = 1'b0;
        #10;
        chkIdle("reset");
        @(negedge clock);
        clear_n = 1'b1;
        tick();
        chkIdle("post_reset");
        $display("txn reset pc=0x%08h", pc_out);

        // Plain increment and load-over-increment priority
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        mPc = mPc + 32'h1;
        chkIdle("inc");
        pc_inc  = 1'b1;
        pc_load = 1'b1;
        bus_in  = 32'h0000_0010;
        tick();
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        mPc = 32'h0000_0010;
        chkIdle("load_over_inc");
        $display("txn load_over_inc pc=0x%08h", pc_out);

        // Taken forward
        doBranch("fwd_taken", 19'h00005, 1'b1);
        chk("fwd_taken.pc_abs", pc_out, 32'h0000_0015);

        // Taken backward wrap, then not taken
        loadPc("bwd", 32'h0000_0002);
        doBranch("bwd_taken", 19'h7FFFC, 1'b1);
        chk("bwd_taken.pc_abs", pc_out, 32'hFFFF_FFFE);
        loadPc("nt", 32'h0000_0002);
        doBranch("not_taken", 19'h7FFFC, 1'b0);
        chk("not_taken.pc_abs", pc_out, 32'h0000_0002);

        // Increment wrap
        loadPc("wrap", 32'hFFFF_FFFF);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        mPc = 32'h0;
        chkIdle("inc_wrap");
        $display("txn inc_wrap pc=0x%08h", pc_out);

        // Collision: pc_inc during EVAL, then pc_load during COMMIT aborts a taken branch
        loadPc("coll", 32'h0000_0100);
        branch_req = 1'b1;
        offset     = 19'h00005;
        tick();
        branch_req = 1'b0;
        con_in     = 1'b1;
        pc_inc     = 1'b1;
        tick();
        pc_inc = 1'b0;
        con_in = 1'b0;
        mOvl   = 1'b1;
        chk("coll.eval.pc",      pc_out, mPc);
        chk("coll.eval.overlap", 32'(overlap_err), 32'h1);
        chk("coll.eval.busy",    32'(busy), 32'h1);
        pc_load = 1'b1;
        bus_in  = 32'h0000_0400;
        tick();
        pc_load = 1'b0;
        mPc = 32'h0000_0400;
        chkIdle("coll.commit_load");
        tick();
        chkIdle("coll.after");
        $display("txn collision pc=0x%08h ovl=%0d", pc_out, overlap_err);

        // Saturation of the 4-bit statistics
        for (int i = 0; i < 16; i++) begin
            doBranch($sformatf("sat%0d", i), 19'h00001, 1'b1);
        end
        chk("sat.bcnt_full", 32'(branch_cnt), 32'hF);
        chk("sat.tcnt_full", 32'(taken_cnt), 32'hF);

        // Asynchronous reset in the middle of EVAL
        branch_req = 1'b1;
        offset     = 19'h00007;
        tick();
        branch_req = 1'b0;
        con_in     = 1'b1;
        chk("rst.eval.busy", 32'(busy), 32'h1);
        #3 clear_n = 1'b0;
        #1;
        mPc = 32'h0; mB = 4'h0; mT = 4'h0; mOvl = 1'b0;
        chkIdle("rst_async");
        @(negedge clock);
        clear_n = 1'b1;
        con_in  = 1'b0;
        tick();
        chkIdle("rst.after1");
        tick();
        chkIdle("rst.after2");
        $display("txn reset_mid_eval pc=0x%08h busy=%0d", pc_out, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
